// File: rtl/route_compute_share_ctrl.sv
// Round-robin sharing of a single look-ahead route-computation unit among NREQ input VCs.
// Optional DfD trace capture is enabled by defining ROUTE_SHARE_DFD_TRACE_EN.
module route_compute_share_ctrl #(
  parameter  int NREQ   = 4,
  parameter  int EAw    = 3,
  parameter  int DSTPw  = 4,
  parameter  int RC_LAT = 1,
  localparam int IDw    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*EAw-1:0]   req_dest_e_addr,
  input  logic [NREQ*DSTPw-1:0] req_destport,
  output logic [NREQ-1:0]       gnt,
  output logic                  rc_valid,
  output logic [EAw-1:0]        rc_dest_e_addr,
  output logic [DSTPw-1:0]      rc_destport,
  input  logic [DSTPw-1:0]      rc_lkdestport,
  output logic                  rsp_valid,
  output logic [IDw-1:0]        rsp_id,
  output logic [DSTPw-1:0]      rsp_lkdestport,
  output logic                  busy
`ifdef ROUTE_SHARE_DFD_TRACE_EN
  ,
  input  logic                  rc_trigger,
  input  logic [31:0]           rc_trace,
  output logic [15:0]           dbg_trig_cnt,
  output logic [31:0]           dbg_trace
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [1:0] CNT_INIT = (RC_LAT > 0) ? 2'(RC_LAT - 1) : 2'd0;

  state_e           state_q, state_d;
  logic [IDw-1:0]   rr_q, rr_d;
  logic [IDw-1:0]   id_q, id_d;
  logic [EAw-1:0]   addr_q, addr_d;
  logic [DSTPw-1:0] dport_q, dport_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [DSTPw-1:0] lk_q, lk_d;
  logic [IDw-1:0]   last_id_q, last_id_d;
  logic [DSTPw-1:0] last_lk_q, last_lk_d;
  logic             capture;
  logic             win_found;
  logic [IDw-1:0]   win_id;

  // Rotating priority: first set request at or above rr_q, wrapping to 0.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDw'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    dport_d   = dport_q;
    cnt_d     = cnt_q;
    lk_d      = lk_q;
    last_id_d = last_id_q;
    last_lk_d = last_lk_q;
    capture   = 1'b0;
    rc_valid  = 1'b0;
    rsp_valid = 1'b0;
    gnt       = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d    = win_id;
          addr_d  = req_dest_e_addr[int'(win_id)*EAw +: EAw];
          dport_d = req_destport[int'(win_id)*DSTPw +: DSTPw];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rc_valid = 1'b1;
        if (RC_LAT == 0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        // A requester that dropped its request meanwhile gets no response.
        if (req[id_q]) begin
          rsp_valid   = 1'b1;
          gnt[id_q]   = 1'b1;
          last_id_d   = id_q;
          last_lk_d   = lk_q;
        end
        rr_d    = (id_q == IDw'(NREQ - 1)) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) lk_d = rc_lkdestport;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      dport_q   <= '0;
      cnt_q     <= '0;
      lk_q      <= '0;
      last_id_q <= '0;
      last_lk_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      dport_q   <= dport_d;
      cnt_q     <= cnt_d;
      lk_q      <= lk_d;
      last_id_q <= last_id_d;
      last_lk_q <= last_lk_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign rc_dest_e_addr = busy ? addr_q : '0;
  assign rc_destport    = busy ? dport_q : '0;
  assign rsp_id         = rsp_valid ? id_q : last_id_q;
  assign rsp_lkdestport = rsp_valid ? lk_q : last_lk_q;

`ifdef ROUTE_SHARE_DFD_TRACE_EN
  logic [15:0] dbg_cnt_q;
  logic [31:0] dbg_trace_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dbg_cnt_q   <= '0;
      dbg_trace_q <= '0;
    end else if (capture && rc_trigger) begin
      if (dbg_cnt_q != '1) dbg_cnt_q <= dbg_cnt_q + 16'd1;
      dbg_trace_q <= rc_trace;
    end
  end

  assign dbg_trig_cnt = dbg_cnt_q;
  assign dbg_trace    = dbg_trace_q;
`endif

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));

endmodule

// File: tb/tb_route_compute_share_ctrl.sv
// Randomized bench for route_compute_share_ctrl against a transaction-level round-robin model.
// Build with ROUTE_SHARE_DFD_TRACE_EN defined to also cover the DfD trace outputs.
module tb_route_compute_share_ctrl;
  parameter int RC_LAT = 1;
  localparam int NREQ  = 4;
  localparam int EAw   = 3;
  localparam int DSTPw = 4;
  localparam int IDw   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*EAw-1:0]   req_dest_e_addr;
  logic [NREQ*DSTPw-1:0] req_destport;
  logic [NREQ-1:0]       gnt;
  logic                  rc_valid;
  logic [EAw-1:0]        rc_dest_e_addr;
  logic [DSTPw-1:0]      rc_destport;
  logic [DSTPw-1:0]      rc_lkdestport;
  logic                  rsp_valid;
  logic [IDw-1:0]        rsp_id;
  logic [DSTPw-1:0]      rsp_lkdestport;
  logic                  busy;
`ifdef ROUTE_SHARE_DFD_TRACE_EN
  logic                  rc_trigger;
  logic [31:0]           rc_trace;
  logic [15:0]           dbg_trig_cnt;
  logic [31:0]           dbg_trace;
`endif

  logic [EAw-1:0]   addr_a[NREQ];
  logic [DSTPw-1:0] dest_a[NREQ];

  int tests = 0;
  int fails = 0;
  int m_rr, m_last_id, m_last_lk, m_dbg_cnt;
  logic [31:0] m_dbg_trace;

  always #5 clk = ~clk;

  always_comb begin
    req_dest_e_addr = '0;
    req_destport    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_dest_e_addr[i*EAw +: EAw] = addr_a[i];
      req_destport[i*DSTPw +: DSTPw] = dest_a[i];
    end
  end

  route_compute_share_ctrl #(.NREQ(NREQ), .EAw(EAw), .DSTPw(DSTPw), .RC_LAT(RC_LAT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_dest_e_addr(req_dest_e_addr), .req_destport(req_destport),
    .gnt(gnt), .rc_valid(rc_valid), .rc_dest_e_addr(rc_dest_e_addr),
    .rc_destport(rc_destport), .rc_lkdestport(rc_lkdestport),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_lkdestport(rsp_lkdestport),
    .busy(busy)
`ifdef ROUTE_SHARE_DFD_TRACE_EN
    , .rc_trigger(rc_trigger), .rc_trace(rc_trace),
    .dbg_trig_cnt(dbg_trig_cnt), .dbg_trace(dbg_trace)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_rr + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_last_id = 0; m_last_lk = 0; m_dbg_cnt = 0; m_dbg_trace = '0;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = EAw'($urandom);
      dest_a[i] = DSTPw'($urandom);
    end
  endtask

  // Starts in an IDLE cycle; ends in the following IDLE cycle.
  task automatic do_op(input logic [3:0] rv, input bit withdraw, input logic [3:0] lk,
                       input bit trig, input logic [31:0] tr, output int served);
    int w;
    logic [EAw-1:0] ea;
    logic [DSTPw-1:0] ed;
    logic [3:0] cur;
    logic [3:0] eg;
    bit expv;
    req = rv;
    w = pick(rv);
    served = w;
    rc_lkdestport = DSTPw'($urandom);
`ifdef ROUTE_SHARE_DFD_TRACE_EN
    rc_trigger = 1'($urandom); rc_trace = $urandom;
`endif
    step();
    if (w < 0) begin
      tests++;
      if (busy !== 1'b0 || rc_valid !== 1'b0) begin
        fails++; $display("FAIL idle_noreq busy=%b rc_valid=%b exp 0 0", busy, rc_valid);
      end
      return;
    end
    ea = addr_a[w];
    ed = dest_a[w];
    for (int c = 1; c <= RC_LAT + 1; c++) begin
      tests++;
      if (busy !== 1'b1 || rc_valid !== (c == 1) || gnt !== '0 || rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL op_ctl c=%0d busy=%b rc_valid=%b gnt=%b rsp_valid=%b exp 1 %b 0000 0",
                 c, busy, rc_valid, gnt, rsp_valid, (c == 1));
      end
      tests++;
      if (rc_dest_e_addr !== ea || rc_destport !== ed) begin
        fails++;
        $display("FAIL operands c=%0d addr=%0h dport=%0h exp %0h %0h", c, rc_dest_e_addr, rc_destport, ea, ed);
      end
      randomize_operands();
      cur = 4'($urandom);
      cur[w] = !(withdraw && c == RC_LAT + 1);
      req = cur;
      if (c == RC_LAT + 1) begin
        rc_lkdestport = lk;
`ifdef ROUTE_SHARE_DFD_TRACE_EN
        rc_trigger = trig; rc_trace = tr;
        if (trig) begin
          if (m_dbg_cnt < 16'hFFFF) m_dbg_cnt++;
          m_dbg_trace = tr;
        end
`endif
      end else begin
        rc_lkdestport = DSTPw'($urandom);
`ifdef ROUTE_SHARE_DFD_TRACE_EN
        rc_trigger = 1'($urandom); rc_trace = $urandom;
`endif
      end
      step();
    end
    expv = !withdraw;
    eg = expv ? 4'(1 << w) : 4'b0000;
    tests++;
    if (rsp_valid !== expv || gnt !== eg || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_ctl rsp_valid=%b gnt=%b busy=%b exp %b %b 1", rsp_valid, gnt, busy, expv, eg);
    end
    if (expv) begin
      m_last_id = w;
      m_last_lk = int'(lk);
    end
    m_rr = (w + 1) % NREQ;
    tests++;
    if (rsp_id !== IDw'(m_last_id) || rsp_lkdestport !== DSTPw'(m_last_lk)) begin
      fails++;
      $display("FAIL done_data rsp_id=%0d lk=%0h exp %0d %0h", rsp_id, rsp_lkdestport, m_last_id, m_last_lk);
    end
    step();
    tests++;
    if (busy !== 1'b0 || rc_valid !== 1'b0 || gnt !== '0 || rsp_valid !== 1'b0 ||
        rc_dest_e_addr !== '0 || rc_destport !== '0) begin
      fails++;
      $display("FAIL idle_after busy=%b rc_valid=%b gnt=%b rsp_valid=%b addr=%0h dport=%0h exp all 0",
               busy, rc_valid, gnt, rsp_valid, rc_dest_e_addr, rc_destport);
    end
    tests++;
    if (rsp_id !== IDw'(m_last_id) || rsp_lkdestport !== DSTPw'(m_last_lk)) begin
      fails++;
      $display("FAIL hold_data rsp_id=%0d lk=%0h exp %0d %0h", rsp_id, rsp_lkdestport, m_last_id, m_last_lk);
    end
`ifdef ROUTE_SHARE_DFD_TRACE_EN
    tests++;
    if (dbg_trig_cnt !== 16'(m_dbg_cnt) || dbg_trace !== m_dbg_trace) begin
      fails++;
      $display("FAIL dbg cnt=%0d trace=%h exp %0d %h", dbg_trig_cnt, dbg_trace, m_dbg_cnt, m_dbg_trace);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0;
    step(); step();
    tests++;
    if (busy !== 1'b0 || rc_valid !== 1'b0 || gnt !== '0 || rsp_valid !== 1'b0 ||
        rsp_id !== '0 || rsp_lkdestport !== '0 || rc_dest_e_addr !== '0 || rc_destport !== '0) begin
      fails++;
      $display("FAIL reset_state busy=%b rc_valid=%b gnt=%b rsp_valid=%b id=%0d lk=%0h exp all 0",
               busy, rc_valid, gnt, rsp_valid, rsp_id, rsp_lkdestport);
    end
`ifdef ROUTE_SHARE_DFD_TRACE_EN
    tests++;
    if (dbg_trig_cnt !== '0 || dbg_trace !== '0) begin
      fails++; $display("FAIL reset_dbg cnt=%0d trace=%h exp 0 0", dbg_trig_cnt, dbg_trace);
    end
`endif
    reset = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_fairness();
    int s;
    for (int k = 0; k < 5; k++) begin
      do_op(4'b1111, 1'b0, DSTPw'($urandom), 1'b0, 32'h0, s);
      tests++;
      if (s !== k % NREQ) begin
        fails++; $display("FAIL fairness_order k=%0d served=%0d exp %0d", k, s, k % NREQ);
      end
    end
  endtask

  task automatic test_single();
    int s;
    randomize_operands();
    addr_a[2] = 3'd5;
    dest_a[2] = 4'h3;
    do_op(4'b0100, 1'b0, 4'h9, 1'b1, 32'hDEADBEEF, s);
    tests++;
    if (s !== 2 || rsp_id !== 2'd2 || rsp_lkdestport !== 4'h9) begin
      fails++; $display("FAIL single served=%0d id=%0d lk=%0h exp 2 2 9", s, rsp_id, rsp_lkdestport);
    end
  endtask

  task automatic test_wrap();
    int s0, s1;
    do_op(4'b0011, 1'b0, DSTPw'($urandom), 1'b0, 32'h0, s0);
    do_op(4'b0011, 1'b0, DSTPw'($urandom), 1'b0, 32'h0, s1);
    tests++;
    if (s0 !== 0 || s1 !== 1) begin
      fails++; $display("FAIL wrap served=%0d,%0d exp 0,1", s0, s1);
    end
  endtask

  task automatic test_withdraw();
    int s;
    do_op(4'b0001, 1'b0, DSTPw'($urandom), 1'b0, 32'h0, s);
    do_op(4'b0110, 1'b1, DSTPw'($urandom), 1'b0, 32'h0, s);
    tests++;
    if (s !== 1) begin
      fails++; $display("FAIL withdraw_pick served=%0d exp 1", s);
    end
    do_op(4'b0100, 1'b0, DSTPw'($urandom), 1'b0, 32'h0, s);
    tests++;
    if (s !== 2 || rsp_id !== 2'd2) begin
      fails++; $display("FAIL after_withdraw served=%0d id=%0d exp 2 2", s, rsp_id);
    end
  endtask

  task automatic test_reset_midop();
    int s;
    req = 4'b0010;
    step();
    if (RC_LAT > 0) step();
    reset = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || rc_valid !== 1'b0 || gnt !== '0 || rsp_valid !== 1'b0 ||
        rsp_id !== '0 || rsp_lkdestport !== '0) begin
      fails++;
      $display("FAIL reset_midop busy=%b rc_valid=%b gnt=%b rsp_valid=%b id=%0d lk=%0h exp all 0",
               busy, rc_valid, gnt, rsp_valid, rsp_id, rsp_lkdestport);
    end
    reset = 1'b1;
    req = '0;
    model_reset();
    step();
    do_op(4'b1000, 1'b0, DSTPw'($urandom), 1'b1, $urandom, s);
    tests++;
    if (s !== 3 || rsp_id !== 2'd3) begin
      fails++; $display("FAIL reset_then_serve served=%0d id=%0d exp 3 3", s, rsp_id);
    end
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 60; n++) begin
      randomize_operands();
      do_op(4'($urandom), ($urandom_range(0, 3) == 0), DSTPw'($urandom),
            1'($urandom), $urandom, s);
    end
  endtask

  initial begin
    reset = 1'b0;
    req = '0;
    rc_lkdestport = '0;
`ifdef ROUTE_SHARE_DFD_TRACE_EN
    rc_trigger = 1'b0;
    rc_trace = '0;
`endif
    randomize_operands();
    model_reset();
    test_reset();
    test_fairness();
    test_single();
    test_wrap();
    test_withdraw();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1);
  end

endmodule

// File: doc/route_compute_share_ctrl.md
Name: route_compute_share_ctrl

Overview:
- Time-multiplexes one look-ahead route-computation unit (mesh/torus look-ahead routing path) among NREQ requesting input VCs of a router.
- Round-robin arbitration; per-operation FSM that issues the request, waits a fixed routing latency, captures the result and returns it to the winner.
- Sits between the input-port VC queues and a single shared routing instance. Replaces per-VC routing replication in area-reduced router builds.

Parameters:
- NREQ, 4, number of requesters (1..16)
- EAw, 3, destination endpoint address width
- DSTPw, 4, encoded destination-port width
- RC_LAT, 1, cycles from rc_valid to a valid rc_lkdestport (0..3)
- IDw, log2(NREQ) with minimum 1, requester index width (localparam)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester route request; level, held until gnt
- req_dest_e_addr  in  NREQ*EAw  per-requester destination endpoint address; slice i = [(i+1)*EAw-1:i*EAw]
- req_destport  in  NREQ*DSTPw  per-requester current-router destport_encoded
- gnt  out  NREQ  one-hot completion grant, 1-cycle pulse
- rc_valid  out  1  shared routing unit operand valid
- rc_dest_e_addr  out  EAw  operand to routing unit
- rc_destport  out  DSTPw  operand to routing unit
- rc_lkdestport  in  DSTPw  routing unit result
- rsp_valid  out  1  result valid, 1-cycle pulse
- rsp_id  out  IDw  index of the served requester
- rsp_lkdestport  out  DSTPw  captured look-ahead port
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset is active-low, sampled on the clk rising edge. All outputs are 0, FSM is IDLE, rr_ptr = 0, wait counter = 0. A reset in any state aborts the operation with no gnt or rsp.
- FSM states:
  - IDLE: if |req, select the winner = first set bit scanning from rr_ptr upward with wrap. Latch the winner id, its dest_e_addr and its destport into operand registers. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: rc_valid=1 for exactly 1 cycle. rc_dest_e_addr and rc_destport driven from the operand registers; they are held stable from ISSUE through CAPTURE and are 0 in IDLE. If RC_LAT=0, capture rc_lkdestport this cycle and go to DONE. Else load cnt=RC_LAT-1 and go to WAIT.
  - WAIT: if cnt=0, capture rc_lkdestport and go to DONE. Else decrement cnt.
  - DONE: if req[id] is still 1, assert rsp_valid=1, gnt[id]=1, rsp_id=id and rsp_lkdestport=the captured value. If req[id] is 0, the request was withdrawn: no rsp_valid and no gnt. In both cases rr_ptr = (id+1) mod NREQ, then go to IDLE.
- Latency: req sampled in IDLE at cycle 0; rsp_valid/gnt at cycle RC_LAT+2.
- Throughput: one operation per RC_LAT+3 cycles. No back-to-back overlap; IDLE always lasts ≥1 cycle.
- rsp_id and rsp_lkdestport hold their last value outside DONE. rsp_valid and gnt are 0 outside DONE.
- Requests arriving or changing during ISSUE/WAIT/DONE do not affect the operation in progress. Operands are taken only at the IDLE latch.
- rr_ptr wraps: NREQ-1 → 0. With NREQ=1 the pointer stays 0 and IDw=1.
- gnt has at most one bit set per cycle (checked by assertion).

Optional Feature:
- Macro: ROUTE_SHARE_DFD_TRACE_EN.
- Defined:
  - Extra inputs rc_trigger (1) and rc_trace (32) from the routing unit's DfD outputs.
  - Extra outputs dbg_trig_cnt (16) and dbg_trace (32).
  - In the capture cycle, if rc_trigger=1: dbg_trig_cnt increments, saturating at 0xFFFF, and dbg_trace is loaded with rc_trace.
  - Both outputs reset to 0.
- Not defined: none of these ports exist and no related logic is present.

Test Plan:
- Single request, RC_LAT=1: req=4'b0100, addr2=3'd5, destport2=4'h3; routing returns 4'h9. Required: rc_valid at cycle 1 with rc_dest_e_addr=5, rc_destport=3; rsp_valid, gnt=4'b0100, rsp_id=2, rsp_lkdestport=9 at cycle 3. busy=1 for cycles 1..3.
- Fairness: req=4'b1111 held and each requester re-requested after its gnt. Required: gnt order 0,1,2,3,0; one response every 4 cycles (RC_LAT=1).
- Wrap: rr_ptr=3 after serving 2, req=4'b0011. Required: requester 0 served first, then 1.
- Withdrawal: req[1] dropped during WAIT. Required: in DONE no rsp_valid and gnt=0; next IDLE serves requester 2 when req[2]=1.
- Reset mid-op: reset=0 asserted in WAIT. Required: next cycle busy=0, rc_valid=0, gnt=0, rsp_valid=0; after release, req=4'b1000 is served with rsp_id=3 from rr_ptr=0.
- RC_LAT=0 and RC_LAT=3 builds, plus a ROUTE_SHARE_DFD_TRACE_EN build: responses at cycles 2 and 5 respectively. With DFD enabled, rc_trigger=1 and rc_trace=32'hDEADBEEF at capture give dbg_trig_cnt=1 and dbg_trace=32'hDEADBEEF.
